// File: rtl/dhcp_vlg_pkg.sv
// Shared constants and FSM state type for the DHCP packed-option transmitter.
package dhcp_vlg_pkg;
   // Fixed BOOTP header (236 bytes) plus the 4-byte magic cookie.
   localparam int         DHCP_HDR_LEN = 240;
   localparam logic [7:0] DHCP_OPT_END = 8'hFF;
   localparam logic [7:0] DHCP_OPT_PAD = 8'h00;

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_READY, S_HDR, S_OPT, S_END, S_PAD
   } state_t;
endpackage

// File: rtl/dhcp_vlg_tx_pkd_if.sv
// Byte stream toward the UDP layer plus the frame metadata it needs.
interface dhcp_vlg_tx_pkd_if;
   logic        req;
   logic        rdy;
   logic [7:0]  dat;
   logic        val;
   logic        sof;
   logic        eof;
   logic [15:0] length;
   logic [31:0] meta_src_ip;
   logic [31:0] meta_dst_ip;
   logic [15:0] meta_id;

   modport master (input req, output rdy, dat, val, sof, eof, length,
                   meta_src_ip, meta_dst_ip, meta_id);
   modport slave  (output req, input rdy, dat, val, sof, eof, length,
                   meta_src_ip, meta_dst_ip, meta_id);
endinterface

// File: rtl/dhcp_vlg_opt_ser.sv
// Walks one option slot: code, len, then len payload bytes (byte 0 first).
module dhcp_vlg_opt_ser #(
   parameter int OPT_MAX_LEN = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     adv,
   input  logic [7:0]               code,
   input  logic [7:0]               len,
   input  logic [OPT_MAX_LEN*8-1:0] payload,
   output logic [7:0]               data,
   output logic                     last
);
   localparam int PW = $clog2(OPT_MAX_LEN + 2);

   logic [PW-1:0] pos;
   logic [PW-1:0] pidx;

   // Position within the slot; wraps to 0 once the slot's final byte goes out.
   always_ff @(posedge clk) begin
      if (rst)      pos <= '0;
      else if (adv) pos <= last ? '0 : pos + PW'(1);
   end

   // Byte at the current position and end-of-slot flag.
   always_comb begin
      pidx = pos - PW'(2);
      last = (9'(pos) == (9'(len) + 9'd1));
      data = code;
      if (pos == PW'(1))      data = len;
      else if (pos >= PW'(2)) data = payload[int'(pidx)*8 +: 8];
   end
endmodule

// File: rtl/dhcp_vlg_tx_pkd.sv
// DHCP frame serialiser: header, packed options, END, zero padding.
// Multi-byte buses are little-endian by byte: byte 0 lives in bits [7:0].
module dhcp_vlg_tx_pkd
   import dhcp_vlg_pkg::*;
#(
   parameter int OPT_NUM     = 7,
   parameter int OPT_MAX_LEN = 16,
   parameter int MIN_LEN     = 300
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             hdr_val,
   input  logic [DHCP_HDR_LEN*8-1:0]        hdr,
   input  logic [OPT_NUM-1:0]               opt_pres,
   input  logic [OPT_NUM*8-1:0]             opt_code,
   input  logic [OPT_NUM*8-1:0]             opt_len,
   input  logic [OPT_NUM*OPT_MAX_LEN*8-1:0] opt_dat,
   input  logic [31:0]                      src_ip,
   input  logic [31:0]                      dst_ip,
   input  logic [15:0]                      ipv4_id,
   output logic                             err_len,
   output logic                             busy,
   dhcp_vlg_tx_pkd_if.master                tx
);
   localparam int SW = (OPT_NUM > 1) ? $clog2(OPT_NUM) : 1;
   localparam int HW = $clog2(DHCP_HDR_LEN);

   state_t state, state_nxt;

   logic [DHCP_HDR_LEN*8-1:0]        hdr_l;
   logic [OPT_NUM-1:0]               pres_l, keep;
   logic [OPT_NUM*8-1:0]             code_l, len_l;
   logic [OPT_NUM*OPT_MAX_LEN*8-1:0] dat_l;
   logic [31:0]                      src_l, dst_l;
   logic [15:0]                      id_l, len_acc, cnt, acc_nxt, tot, len_fin;
   logic [SW-1:0]                    slot, first_keep, nxt_keep;
   logic [HW-1:0]                    hidx;
   logic [7:0]                       code_sel, len_sel, ser_data, cur_byte;
   logic                             keep_scan, first_found, nxt_found, ser_last;
   logic                             hdr_last, emit, done, stream;

   assign code_sel  = code_l[int'(slot)*8 +: 8];
   assign len_sel   = len_l[int'(slot)*8 +: 8];
   assign keep_scan = pres_l[slot] && (len_sel <= 8'(OPT_MAX_LEN));
   assign acc_nxt   = len_acc + (keep_scan ? 16'd2 + 16'(len_sel) : 16'd0);
   assign tot       = 16'(DHCP_HDR_LEN) + acc_nxt + 16'd1;
   assign len_fin   = (tot < 16'(MIN_LEN)) ? 16'(MIN_LEN) : tot;
   assign hdr_last  = (hidx == HW'(DHCP_HDR_LEN - 1));

   dhcp_vlg_opt_ser #(.OPT_MAX_LEN(OPT_MAX_LEN)) u_ser (
      .clk     (clk),
      .rst     (rst),
      .adv     (emit && (state == S_OPT)),
      .code    (code_sel),
      .len     (len_sel),
      .payload (dat_l[int'(slot)*OPT_MAX_LEN*8 +: OPT_MAX_LEN*8]),
      .data    (ser_data),
      .last    (ser_last)
   );

   // Lowest kept slot overall and lowest kept slot above the current one.
   always_comb begin
      first_found = 1'b0;
      first_keep  = '0;
      nxt_found   = 1'b0;
      nxt_keep    = '0;
      for (int i = OPT_NUM - 1; i >= 0; i--) begin
         if (keep[i]) begin
            first_found = 1'b1;
            first_keep  = SW'(i);
            if (i > int'(slot)) begin
               nxt_found = 1'b1;
               nxt_keep  = SW'(i);
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state, byte source select and status outputs.
   always_comb begin
      state_nxt = state;
      cur_byte  = DHCP_OPT_PAD;
      stream    = (state == S_READY) || (state == S_HDR) || (state == S_OPT) ||
                  (state == S_END)   || (state == S_PAD);
      done      = stream && (cnt == tx.length);
      emit      = stream && tx.req && !done;
      busy      = (state != S_IDLE);
      err_len   = (state == S_SCAN) && pres_l[slot] && !keep_scan;
      case (state)
         S_IDLE:  if (hdr_val) state_nxt = S_SCAN;
         S_SCAN:  if (slot == SW'(OPT_NUM - 1)) state_nxt = S_READY;
         S_READY, S_HDR: begin
            cur_byte = hdr_l[int'(hidx)*8 +: 8];
            if (emit) state_nxt = !hdr_last ? S_HDR : (first_found ? S_OPT : S_END);
         end
         S_OPT: begin
            cur_byte = ser_data;
            if (emit && ser_last) state_nxt = nxt_found ? S_OPT : S_END;
         end
         S_END: begin
            cur_byte = DHCP_OPT_END;
            if (emit) state_nxt = S_PAD;
         end
         default: ;
      endcase
      // All length bytes out (eof cycle has just been shown): back to IDLE.
      if (done) state_nxt = S_IDLE;
   end

   // Input latch, scan accumulation, byte counters and registered stream outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         hdr_l <= '0; pres_l <= '0; code_l <= '0; len_l <= '0; dat_l <= '0;
         src_l <= '0; dst_l <= '0; id_l <= '0;
         slot <= '0; hidx <= '0; cnt <= '0; len_acc <= '0; keep <= '0;
         tx.rdy <= 1'b0; tx.dat <= '0; tx.val <= 1'b0; tx.sof <= 1'b0; tx.eof <= 1'b0;
         tx.length <= '0; tx.meta_src_ip <= '0; tx.meta_dst_ip <= '0; tx.meta_id <= '0;
      end else begin
         tx.val <= emit;
         tx.sof <= emit && (cnt == 16'd0);
         tx.eof <= emit && (cnt == tx.length - 16'd1);
         tx.dat <= emit ? cur_byte : 8'h00;
         if (emit) cnt <= cnt + 16'd1;
         case (state)
            S_IDLE: if (hdr_val) begin
               hdr_l <= hdr; pres_l <= opt_pres; code_l <= opt_code; len_l <= opt_len;
               dat_l <= opt_dat; src_l <= src_ip; dst_l <= dst_ip; id_l <= ipv4_id;
               slot <= '0; hidx <= '0; cnt <= '0; len_acc <= '0; keep <= '0;
            end
            S_SCAN: begin
               keep[slot] <= keep_scan;
               len_acc    <= acc_nxt;
               if (slot == SW'(OPT_NUM - 1)) begin
                  slot           <= '0;
                  tx.length      <= len_fin;
                  tx.rdy         <= 1'b1;
                  tx.meta_src_ip <= src_l;
                  tx.meta_dst_ip <= dst_l;
                  tx.meta_id     <= id_l;
               end else begin
                  slot <= slot + SW'(1);
               end
            end
            S_READY, S_HDR: if (emit) begin
               hidx <= hidx + HW'(1);
               if (hdr_last) slot <= first_keep;
            end
            S_OPT: if (emit && ser_last) slot <= nxt_keep;
            default: ;
         endcase
         if (done) tx.rdy <= 1'b0;
      end
   end
endmodule
